// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/bubble controller for the 5-stage in-order pipe  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       decode_i_rs1,
  input  logic [4:0]       decode_i_rs2,
  input  logic             decode_i_rs1_ren,
  input  logic             decode_i_rs2_ren,
  input  logic [4:0]       regE_i_rd,
  input  logic             regE_i_reg_wen,
  input  logic             regE_i_is_load,
  input  logic             execute_i_redirect,
  input  logic             execute_i_mdu_busy,
  input  logic             fetch_i_imem_valid,
  input  logic             regM_i_mem_req,
  input  logic             memory_i_dmem_ready,
  output logic             regF_stall,
  output logic             regD_stall,
  output logic             regE_stall,
  output logic             regM_stall,
  output logic             regW_stall,
  output logic             regD_bubble,
  output logic             regE_bubble,
  output logic             regM_bubble,
  output logic             regW_bubble,
  output logic [1:0]       ctrl_o_state,
  output logic [CNT_W-1:0] ctrl_o_stall_cnt,
  output logic             ctrl_o_timeout
);

  localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  logic              w_mem_stall;
  logic              w_rs1_hit;
  logic              w_rs2_hit;
  logic              w_load_use;

  assign w_mem_stall = regM_i_mem_req & ~memory_i_dmem_ready;
  assign w_rs1_hit   = decode_i_rs1_ren & (decode_i_rs1 == regE_i_rd);
  assign w_rs2_hit   = decode_i_rs2_ren & (decode_i_rs2 == regE_i_rd);
  assign w_load_use  = regE_i_is_load & regE_i_reg_wen & (regE_i_rd != 5'd0)
                     & (w_rs1_hit | w_rs2_hit);

  // Priority-ordered hazard resolution; the first matching hazard owns the controls.
  always_comb begin
    regF_stall   = 1'b0;
    regD_stall   = 1'b0;
    regE_stall   = 1'b0;
    regM_stall   = 1'b0;
    regW_stall   = 1'b0;
    regD_bubble  = 1'b0;
    regE_bubble  = 1'b0;
    regM_bubble  = 1'b0;
    regW_bubble  = 1'b0;
    redir_pend_d = redir_pend_q;
    if (rst) begin
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
      regM_bubble = 1'b1;
      regW_bubble = 1'b1;
    end else if (state_q == ST_TIMEOUT) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_stall  = 1'b1;
      regW_stall  = 1'b1;
      regW_bubble = 1'b1;
    end else if (w_mem_stall) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_stall  = 1'b1;
      regW_bubble = 1'b1;
    end else if (execute_i_mdu_busy) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_stall  = 1'b1;
      regM_bubble = 1'b1;
    end else if (execute_i_redirect) begin
      regD_bubble = 1'b1;
      regE_bubble = 1'b1;
      // An outstanding icache miss will return a wrong-path instruction later.
      if (!fetch_i_imem_valid) begin
        redir_pend_d = 1'b1;
      end
    end else if (w_load_use) begin
      regF_stall  = 1'b1;
      regD_stall  = 1'b1;
      regE_bubble = 1'b1;
    end else if (!fetch_i_imem_valid) begin
      regF_stall  = 1'b1;
      regD_bubble = 1'b1;
    end else if (redir_pend_q) begin
      regD_bubble  = 1'b1;
      redir_pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    wd_cnt_d = w_mem_stall ? (wd_cnt_q + 1'b1) : '0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_stall && (wd_cnt_q == WD_LAST)) begin
          state_d = ST_TIMEOUT;
        end else if (w_mem_stall) begin
          state_d = ST_MEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TIMEOUT: begin
        state_d  = ST_TIMEOUT;
        wd_cnt_d = wd_cnt_q;
      end
      default: state_d = ST_RUN;
    endcase
    // Tracks next state so the flag and ctrl_o_state switch on the same edge.
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (regF_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wd_cnt_q     <= '0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_cnt_q     <= wd_cnt_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ctrl_o_state     = state_q;
  assign ctrl_o_stall_cnt = stall_cnt_q;
  assign ctrl_o_timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          rs1_ren, rs2_ren, reg_wen, is_load;
  logic          redirect, mdu_busy, imem_valid, mem_req, dmem_ready;
  logic          f_st, d_st, e_st, m_st, w_st;
  logic          d_bb, e_bb, m_bb, w_bb;
  logic [1:0]    state;
  logic [CW-1:0] scnt;
  logic          tmo;
  logic [4:0]    stl;
  logic [3:0]    bub;

  int n_chk  = 0;
  int n_pass = 0;

  assign stl = {f_st, d_st, e_st, m_st, w_st};
  assign bub = {d_bb, e_bb, m_bb, w_bb};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .decode_i_rs1        (rs1),
    .decode_i_rs2        (rs2),
    .decode_i_rs1_ren    (rs1_ren),
    .decode_i_rs2_ren    (rs2_ren),
    .regE_i_rd           (rd),
    .regE_i_reg_wen      (reg_wen),
    .regE_i_is_load      (is_load),
    .execute_i_redirect  (redirect),
    .execute_i_mdu_busy  (mdu_busy),
    .fetch_i_imem_valid  (imem_valid),
    .regM_i_mem_req      (mem_req),
    .memory_i_dmem_ready (dmem_ready),
    .regF_stall          (f_st),
    .regD_stall          (d_st),
    .regE_stall          (e_st),
    .regM_stall          (m_st),
    .regW_stall          (w_st),
    .regD_bubble         (d_bb),
    .regE_bubble         (e_bb),
    .regM_bubble         (m_bb),
    .regW_bubble         (w_bb),
    .ctrl_o_state        (state),
    .ctrl_o_stall_cnt    (scnt),
    .ctrl_o_timeout      (tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_ren = 1'b0; rs2_ren = 1'b0; reg_wen = 1'b0; is_load = 1'b0;
    redirect = 1'b0; mdu_busy = 1'b0; imem_valid = 1'b1;
    mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance one edge; inputs are changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_stl", 32'(stl), 32'h00);
    chk("rst_bub", 32'(bub), 32'hF);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(scnt), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    do_reset();

    // Load-use on rs1, then idle, then the x0 destination case.
    is_load = 1'b1; reg_wen = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_ren = 1'b1;
    #1;
    chk("lu_stl", 32'(stl), 32'b11000);
    chk("lu_bub", 32'(bub), 32'b0100);
    tick(); idle(); #1;
    chk("lu_after_stl", 32'(stl), 32'b00000);
    is_load = 1'b1; reg_wen = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_ren = 1'b1;
    #1;
    chk("lu_x0_stl", 32'(stl), 32'b00000);
    chk("lu_x0_bub", 32'(bub), 32'b0000);
    tick(); idle(); #1;
    chk("lu_cnt", 32'(scnt), 32'd1);

    // Dcache wait: three stalled cycles, load-use overlapped on the first.
    mem_req = 1'b1; dmem_ready = 1'b0;
    is_load = 1'b1; reg_wen = 1'b1; rd = 5'd7; rs2 = 5'd7; rs2_ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dc_stl", 32'(stl), 32'b11110);
      chk("dc_bub", 32'(bub), 32'b0001);
      chk("dc_state", 32'(state), (i == 0) ? 32'd0 : 32'd1);
      tick();
      is_load = 1'b0;
    end
    dmem_ready = 1'b1;
    #1;
    chk("dc_rel_stl", 32'(stl), 32'b00000);
    chk("dc_rel_state", 32'(state), 32'd1);
    tick(); idle(); #1;
    chk("dc_done_state", 32'(state), 32'd0);
    chk("dc_cnt", 32'(scnt), 32'd4);

    // Redirect while the icache is missing; stale fetch dropped on return.
    redirect = 1'b1; imem_valid = 1'b0;
    #1;
    chk("rd_stl", 32'(stl), 32'b00000);
    chk("rd_bub", 32'(bub), 32'b1100);
    tick(); redirect = 1'b0; imem_valid = 1'b0; #1;
    chk("rd_miss_stl", 32'(stl), 32'b10000);
    chk("rd_miss_bub", 32'(bub), 32'b1000);
    tick(); imem_valid = 1'b1; #1;
    chk("rd_ret_stl", 32'(stl), 32'b00000);
    chk("rd_ret_bub", 32'(bub), 32'b1000);
    tick(); #1;
    chk("rd_next_bub", 32'(bub), 32'b0000);
    chk("rd_cnt", 32'(scnt), 32'd5);

    // MDU occupancy hides a simultaneous redirect until it releases.
    mdu_busy = 1'b1; redirect = 1'b1;
    #1;
    chk("mdu_stl", 32'(stl), 32'b11100);
    chk("mdu_bub", 32'(bub), 32'b0010);
    tick(); mdu_busy = 1'b0; #1;
    chk("mdu_rd_stl", 32'(stl), 32'b00000);
    chk("mdu_rd_bub", 32'(bub), 32'b1100);
    tick(); idle(); #1;
    chk("mdu_idle_bub", 32'(bub), 32'b0000);
    chk("mdu_cnt", 32'(scnt), 32'd6);

    // Reset discards a pending redirect.
    redirect = 1'b1; imem_valid = 1'b0;
    tick();
    do_reset();
    #1;
    chk("rp_bub", 32'(bub), 32'b0000);
    chk("rp_stl", 32'(stl), 32'b00000);
    tick();

    // Watchdog trip after TO consecutive mem stalls; terminal, counter saturates.
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_stl", 32'(stl), 32'b11110);
      chk("wd_tmo", 32'(tmo), 32'd0);
      tick();
    end
    #1;
    chk("wd_trip_stl", 32'(stl), 32'b11111);
    chk("wd_trip_bub", 32'(bub), 32'b0001);
    chk("wd_trip_state", 32'(state), 32'd2);
    chk("wd_trip_tmo", 32'(tmo), 32'd1);
    chk("wd_trip_cnt", 32'(scnt), 32'd4);
    idle();
    for (int i = 0; i < 16; i++) tick();
    #1;
    chk("wd_hold_stl", 32'(stl), 32'b11111);
    chk("wd_hold_state", 32'(state), 32'd2);
    chk("wd_sat_cnt", 32'(scnt), 32'hF);
    do_reset();

    // Ready arriving on the would-be trip cycle prevents the timeout.
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    dmem_ready = 1'b1;
    #1;
    chk("wd2_stl", 32'(stl), 32'b00000);
    tick(); idle(); #1;
    chk("wd2_state", 32'(state), 32'd0);
    chk("wd2_tmo", 32'(tmo), 32'd0);
    chk("wd2_cnt", 32'(scnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
